riscv_uart_tx: RTL and testbench

RISCV_UART_TX -- requirements
Module: riscv_uart_tx

---
 rtl/riscv_uart_tx_if.sv | 13 +
 rtl/riscv_uart_tx.sv | 144 ++++++++++++++
 tb/tb_riscv_uart_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_uart_tx_if.sv
// CPU data-bus view of the UART TX register window.
// The master drives the address and write strobes; the slave returns the select and read data.
interface riscv_uart_tx_if;
  logic [31:0] addr;
  logic        wr_en;
  logic [3:0]  byte_sel;
  logic [31:0] wr_data;
  logic        sel;
  logic [31:0] rd_data;

  modport master (output addr, wr_en, byte_sel, wr_data, input sel, rd_data);
  modport slave  (input addr, wr_en, byte_sel, wr_data, output sel, rd_data);
endinterface

// File: rtl/riscv_uart_tx.sv
// Memory-mapped UART transmitter: a byte FIFO feeding an 8N1 serial framer.
// The register window holds TXDATA (push a byte) and STATUS ({ovf, busy, empty, full}).
module riscv_uart_tx #(
  parameter logic [31:0] UART_BASE_ADDR = 32'h1000_0000,
  parameter int          CLKS_PER_BIT   = 16,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_uart_dmem_addr,
  input  logic        i_uart_dmem_wr_en,
  input  logic [3:0]  i_uart_dmem_byte_sel,
  input  logic [31:0] i_uart_dmem_wr_data,
  output logic        o_uart_sel,
  output logic [31:0] o_uart_rd_data,
  output logic        o_uart_txd,
  output logic        o_uart_busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic fifo_full, fifo_empty, bit_done;
  logic wr_txdata, push, pop, ovf_set, ovf_clr;
  logic unused_bits;

  assign unused_bits = ^{i_uart_dmem_addr[1:0], i_uart_dmem_byte_sel[3:1],
                         i_uart_dmem_wr_data[31:8]};

  // Address decode and register strobes
  assign o_uart_sel = (i_uart_dmem_addr[31:3] == UART_BASE_ADDR[31:3]);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign bit_done   = (baud_cnt == BAUD_LAST);

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign wr_txdata = o_uart_sel && i_uart_dmem_wr_en && !i_uart_dmem_addr[2]
                     && i_uart_dmem_byte_sel[0];
  assign push      = wr_txdata && !fifo_full;
  assign ovf_set   = wr_txdata && fifo_full;
  assign ovf_clr   = o_uart_sel && i_uart_dmem_wr_en && i_uart_dmem_addr[2]
                     && i_uart_dmem_byte_sel[0] && i_uart_dmem_wr_data[3];

  always_comb begin
    o_uart_rd_data = '0;
    if (o_uart_sel && i_uart_dmem_addr[2])
      o_uart_rd_data = {28'b0, ovf, o_uart_busy, fifo_empty, fifo_full};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = START;
             end
      START: if (bit_done) state_next = DATA;
      DATA:  if (bit_done && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_done) begin
               if (!fifo_empty) begin
                 pop        = 1'b1;
                 state_next = START;
               end else begin
                 state_next = IDLE;
               end
             end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_uart_txd  = 1'b1;
    o_uart_busy = !fifo_empty || (state != IDLE);
    case (state)
      START:   o_uart_txd = 1'b0;
      DATA:    o_uart_txd = shift_reg[0];
      default: o_uart_txd = 1'b1;
    endcase
  end

  // Baud counter reloads on every state entry (including STOP -> START).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_next != state || state == IDLE) baud_cnt <= '0;
      else                                      baud_cnt <= baud_cnt + 1'b1;

      if (state != DATA)  bit_idx <= '0;
      else if (bit_done)  bit_idx <= bit_idx + 3'd1;

      if (pop)                          shift_reg <= fifo_mem[rd_ptr];
      else if (state == DATA && bit_done) shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf <= ovf_set || (ovf && !ovf_clr);
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so stale entries are never observable.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_uart_dmem_wr_data[7:0];
  end

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Self-checking bench for riscv_uart_tx: directed and random byte streams are
// decoded by a line receiver and compared with the bytes the bench wrote.
module tb_riscv_uart_tx;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam int          HALF  = CPB / 2;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic clk, rst_n, txd, busy;
  riscv_uart_tx_if bus ();

  riscv_uart_tx #(.UART_BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk                (clk),
    .i_rstn               (rst_n),
    .i_uart_dmem_addr     (bus.addr),
    .i_uart_dmem_wr_en    (bus.wr_en),
    .i_uart_dmem_byte_sel (bus.byte_sel),
    .i_uart_dmem_wr_data  (bus.wr_data),
    .o_uart_sel           (bus.sel),
    .o_uart_rd_data       (bus.rd_data),
    .o_uart_txd           (txd),
    .o_uart_busy          (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Line receiver: frame starts, decoded bytes, framing errors
  int         start_q[$];
  logic [7:0] rx_q[$];
  int         frame_err = 0;
  logic       mon_active = 1'b0;
  int         mon_t = 0;
  logic [7:0] rx_byte = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active <= 1'b0;
      mon_t      <= 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active <= 1'b1;
        mon_t      <= 1;
        start_q.push_back(cyc);
      end
    end else begin
      if (mon_t == HALF && txd !== 1'b0) frame_err <= frame_err + 1;
      if (mon_t >= HALF + CPB && mon_t < HALF + 9 * CPB && (mon_t - HALF) % CPB == 0)
        rx_byte[(mon_t - HALF - CPB) / CPB] <= txd;
      if (mon_t == HALF + 9 * CPB) begin
        if (txd !== 1'b1) frame_err <= frame_err + 1;
        rx_q.push_back(rx_byte);
        mon_active <= 1'b0;
      end
      mon_t <= mon_t + 1;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                       input logic we);
    bus.addr     = a;
    bus.byte_sel = be;
    bus.wr_data  = d;
    bus.wr_en    = we;
  endtask

  task automatic write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    drive(a, be, d, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    drive(BASE + 32'd4, 4'h0, 32'h0, 1'b0);
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'b0, busy}, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  // Expected bytes in order, back-to-back frames spaced exactly one frame apart.
  task automatic check_stream(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    for (int i = 1; i < start_q.size(); i++)
      check({tag, "_gap"}, start_q[i] - start_q[i-1], FRAME);
    check({tag, "_framing"}, frame_err, 0);
    start_q.delete();
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] frame_bits;
    logic       exp_bit;
    int         n;

    rst_n = 1'b0;
    drive(32'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    read_status("rst_status", 32'h2);
    rst_n = 1'b1;
    @(negedge clk);

    // Register read decode
    drive(BASE, 4'h0, 32'h0, 1'b0);
    #1;
    check("txdata_read_sel", {31'b0, bus.sel}, 32'h1);
    check("txdata_read", bus.rd_data, 32'h0);
    @(negedge clk);

    // Single byte 0x55: exact waveform and latency
    write(BASE, 4'b0001, 32'hFFFF_FF55);
    check("b55_txd_latency", {31'b0, txd}, 32'h1);
    check("b55_busy_early", {31'b0, busy}, 32'h1);
    frame_bits = 8'h55;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == FRAME) begin
        check("b55_txd_end", {31'b0, txd}, 32'h1);
        check("b55_busy_end", {31'b0, busy}, 32'h0);
      end else if (k % CPB == 0 || k % CPB == CPB - 1) begin
        if (k < CPB)          exp_bit = 1'b0;
        else if (k < 9 * CPB) exp_bit = frame_bits[(k - CPB) / CPB];
        else                  exp_bit = 1'b1;
        check("b55_txd_bit", {31'b0, txd}, {31'b0, exp_bit});
        if (k == FRAME - 1) check("b55_busy_last", {31'b0, busy}, 32'h1);
      end
    end
    wait_idle(50);
    exp_q = '{8'h55};
    check_stream("b55", exp_q);

    // Back-to-back bytes: contiguous frames, order kept
    write(BASE, 4'b0001, 32'h01);
    write(BASE, 4'b0001, 32'h02);
    write(BASE, 4'b0001, 32'h03);
    wait_idle(3 * FRAME + 50);
    check("b2b_span", start_q.size() == 3 ? start_q[2] + FRAME - start_q[0] : -1, 3 * FRAME);
    exp_q = '{8'h01, 8'h02, 8'h03};
    check_stream("b2b", exp_q);

    // Overflow: one byte in flight, DEPTH queued, last dropped
    exp_q.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      frame_bits = 8'($urandom);
      if (i < DEPTH + 1) exp_q.push_back(frame_bits);
      write(BASE + 32'd1, 4'b1111, {24'hABCDEF, frame_bits});
    end
    read_status("ovf_status", 32'hD);
    drive(BASE | 32'h0100_0004, 4'h0, 32'h0, 1'b0);
    #1;
    check("unsel_sel", {31'b0, bus.sel}, 32'h0);
    check("unsel_rd", bus.rd_data, 32'h0);
    write(BASE + 32'd4, 4'b0001, 32'h8);
    read_status("ovf_cleared", 32'h5);
    wait_idle((DEPTH + 1) * FRAME + 50);
    read_status("ovf_drained", 32'h2);
    check_stream("ovf", exp_q);

    // Decode: out of window, wrong byte lane
    drive(BASE + 32'd8, 4'b0001, 32'h5A, 1'b1);
    #1;
    check("dec_outside_sel", {31'b0, bus.sel}, 32'h0);
    @(negedge clk);
    drive(BASE, 4'b0010, 32'h5A5A, 1'b1);
    #1;
    check("dec_lane_sel", {31'b0, bus.sel}, 32'h1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("dec_busy", {31'b0, busy}, 32'h0);
    check("dec_frames", start_q.size(), 0);
    read_status("dec_status", 32'h2);

    // Random streams up to the no-overflow limit
    for (int it = 0; it < 3; it++) begin
      exp_q.delete();
      n = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        frame_bits = 8'($urandom);
        exp_q.push_back(frame_bits);
        write(BASE, 4'b0001, {24'h0, frame_bits});
      end
      wait_idle((DEPTH + 1) * FRAME + 50);
      check_stream("rand", exp_q);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    // Reset in the 4th data bit, second byte queued
    write(BASE, 4'b0001, 32'h00);
    write(BASE, 4'b0001, 32'hC3);
    repeat (4 * CPB + 6) @(negedge clk);
    check("mid_txd_low", {31'b0, txd}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd", {31'b0, txd}, 32'h1);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_status("mid_status", 32'h2);
    repeat (2 * FRAME) @(negedge clk);
    check("mid_no_residual", start_q.size(), 1);
    check("mid_no_rx", rx_q.size(), 0);
    check("mid_busy_after", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
